// File: rtl/mio_bus_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : mio_bus_ctrl
// Brief    : SCPU data-port bus controller. Decodes word accesses to a
//            synchronous data RAM (with programmable wait states) or to the
//            LED / switch / counter peripherals and returns a one-cycle
//            MIO_ready. Define MIO_BUS_ERR_EN to add a bus_err output and make
//            unmapped reads return 32'hDEAD_BEEF.
// Revision : 1.0 - initial release
// =============================================================================
module mio_bus_ctrl #(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic [31:0]       counter_out
`ifdef MIO_BUS_ERR_EN
    ,
    output logic              bus_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_RAM   = 3'd0,
        K_LED   = 3'd1,
        K_SW    = 3'd2,
        K_CNT   = 3'd3,
        K_UNMAP = 3'd4
    } kind_t;

    localparam logic [3:0] c_wait_init = 4'(RAM_WAIT);
`ifdef MIO_BUS_ERR_EN
    localparam logic [31:0] c_unmap_rdata = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] c_unmap_rdata = 32'h0000_0000;
`endif

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d, w_req_kind;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       data_in_q, data_in_d;
    logic              ready_q, ready_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       counter_q, counter_d;
`ifdef MIO_BUS_ERR_EN
    logic              bus_err_q, bus_err_d;
`endif

    // Byte-lane bits carry no information for word-only accesses.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^Addr_out[1:0];

    always_comb begin
        w_req_kind = K_UNMAP;
        if (Addr_out[31:RAM_AW+2] == '0) begin
            w_req_kind = K_RAM;
        end else if (Addr_out[31:28] == 4'hF) begin
            case (Addr_out[3:2])
                2'd0:    w_req_kind = K_LED;
                2'd1:    w_req_kind = K_SW;
                2'd2:    w_req_kind = K_CNT;
                default: w_req_kind = K_UNMAP;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        data_in_d  = data_in_q;
        ready_d    = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        led_d      = led_q;
        counter_d  = counter_q + 32'd1;
`ifdef MIO_BUS_ERR_EN
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    kind_d  = w_req_kind;
                    write_d = mem_w;
                    wdata_d = Data_out;
                    if (w_req_kind == K_RAM) begin
                        state_d    = ST_WAIT;
                        cnt_d      = c_wait_init;
                        ram_addr_d = Addr_out[RAM_AW+1:2];
                        ram_din_d  = Data_out;
                        // Registered strobe lands in the first WAIT cycle only.
                        ram_we_d   = mem_w;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!write_q) begin
                        data_in_d = ram_dout;
                    end
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                case (kind_q)
                    K_LED: begin
                        if (write_q) led_d = wdata_q[15:0];
                        else         data_in_d = {16'h0000, led_q};
                    end
                    K_SW: begin
                        if (!write_q) data_in_d = {16'h0000, sw};
                    end
                    K_CNT: begin
                        if (write_q) counter_d = wdata_q;
                        else         data_in_d = counter_q;
                    end
                    K_UNMAP: begin
`ifdef MIO_BUS_ERR_EN
                        bus_err_d = 1'b1;
`endif
                        if (!write_q) data_in_d = c_unmap_rdata;
                    end
                    default: begin
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= K_UNMAP;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            data_in_q  <= '0;
            ready_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            led_q      <= '0;
            counter_q  <= '0;
`ifdef MIO_BUS_ERR_EN
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            data_in_q  <= data_in_d;
            ready_q    <= ready_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            led_q      <= led_d;
            counter_q  <= counter_d;
`ifdef MIO_BUS_ERR_EN
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign Data_in     = data_in_q;
    assign MIO_ready   = ready_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_we      = ram_we_q;
    assign led         = led_q;
    assign counter_out = counter_q;
`ifdef MIO_BUS_ERR_EN
    assign bus_err     = bus_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_mio_bus_ctrl
// Brief    : Self-checking bench for mio_bus_ctrl: directed vector table,
//            hand-written multi-cycle sequences and random traffic scored
//            against an address-map reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mio_bus_ctrl;

    localparam int RAM_AW   = 10;
    localparam int RAM_WAIT = 1;
    localparam int K_RAM = 0, K_LED = 1, K_SW = 2, K_CNT = 3, K_UNM = 4;
`ifdef MIO_BUS_ERR_EN
    localparam logic [31:0] UNMAP_RD = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] UNMAP_RD = 32'h0000_0000;
`endif

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] sw;
        logic [31:0] rd;
        int          lat;
        logic        err;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              CPU_MIO, mem_w;
    logic [31:0]       Addr_out, Data_out, Data_in;
    logic              MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;
    logic [15:0]       sw, led;
    logic [31:0]       counter_out;
`ifdef MIO_BUS_ERR_EN
    logic              bus_err;
`endif

    mio_bus_ctrl #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
        .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw), .led(led),
`ifdef MIO_BUS_ERR_EN
        .bus_err(bus_err),
`endif
        .counter_out(counter_out)
    );

    always #5 clk = ~clk;

    // External synchronous RAM
    logic        mem_clr;
    logic [31:0] env_mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << RAM_AW); i++) env_mem[i] <= '0;
            ram_dout <= '0;
        end else begin
            if (ram_we) env_mem[ram_addr] <= ram_din;
            ram_dout <= env_mem[ram_addr];
        end
    end

    int                we_cnt = 0;
    logic [RAM_AW-1:0] we_addr = '0;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
        end
    end

    logic [31:0] cyc = '0;
    always @(posedge clk) if (reset) cyc <= cyc + 32'd1;

    // Reference model state
    logic [31:0] ref_mem [0:(1<<RAM_AW)-1];
    logic [15:0] ref_led;
    logic [31:0] cnt_base, cnt_base_cyc, last_rd;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [31:0] a);
        if (a < (32'd4 << RAM_AW)) return K_RAM;
        if (a[31:28] != 4'hF) return K_UNM;
        case (a[3:2])
            2'd0:    return K_LED;
            2'd1:    return K_SW;
            2'd2:    return K_CNT;
            default: return K_UNM;
        endcase
    endfunction

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat, output logic err,
                       output logic [31:0] cnt_rdy, output logic [31:0] cyc_rdy,
                       output int wep, output logic [RAM_AW-1:0] wea);
        int n;
        int we0;
        @(negedge clk);
        we0 = we_cnt;
        CPU_MIO = 1'b1; mem_w = w; Addr_out = a; Data_out = d;
        n = 0; lat = -1;
        while (n < 64) begin
            @(posedge clk); #1;
            n++;
            if (MIO_ready === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        rd = Data_in;
`ifdef MIO_BUS_ERR_EN
        err = bus_err;
`else
        err = 1'b0;
`endif
        cnt_rdy = counter_out;
        cyc_rdy = cyc;
        CPU_MIO = 1'b0;
        wep = we_cnt - we0;
        wea = we_addr;
        @(posedge clk); #1;
        chk("ready_one_cycle", {31'b0, MIO_ready}, 32'd0);
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] cyc_rdy, output logic [31:0] e_rd,
                              output int e_lat, output logic e_err, output int e_we);
        int k;
        k     = kind_of(a);
        e_lat = (k == K_RAM) ? RAM_WAIT + 2 : 1;
        e_err = (k == K_UNM);
        e_we  = (k == K_RAM && w) ? 1 : 0;
        if (w) begin
            case (k)
                K_RAM: ref_mem[a[RAM_AW+1:2]] = d;
                K_LED: ref_led = d[15:0];
                K_CNT: begin cnt_base = d; cnt_base_cyc = cyc_rdy; end
                default: ;
            endcase
        end else begin
            case (k)
                K_RAM:   last_rd = ref_mem[a[RAM_AW+1:2]];
                K_LED:   last_rd = {16'h0000, ref_led};
                K_SW:    last_rd = {16'h0000, sw};
                K_CNT:   last_rd = cnt_base + (cyc_rdy - 32'd1 - cnt_base_cyc);
                default: last_rd = UNMAP_RD;
            endcase
        end
        e_rd = last_rd;
    endtask

    task automatic do_check(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic use_tbl, input logic [31:0] t_rd,
                            input int t_lat, input logic t_err, output logic [31:0] cnt_rdy);
        logic [31:0]       rd, e_rd, cyc_rdy;
        int                lat, e_lat, wep, e_we;
        logic              err, e_err;
        logic [RAM_AW-1:0] wea;
        txn(w, a, d, rd, lat, err, cnt_rdy, cyc_rdy, wep, wea);
        model_step(w, a, d, cyc_rdy, e_rd, e_lat, e_err, e_we);
        if (use_tbl) begin
            e_rd = t_rd; e_lat = t_lat; e_err = t_err;
        end
        chk({tag, "_rdata"}, rd, e_rd);
        chk({tag, "_latency"}, lat, e_lat);
`ifdef MIO_BUS_ERR_EN
        chk({tag, "_bus_err"}, {31'b0, err}, {31'b0, e_err});
`endif
        chk({tag, "_led"}, {16'h0, led}, {16'h0, ref_led});
        chk({tag, "_counter"}, cnt_rdy, cnt_base + (cyc_rdy - cnt_base_cyc));
        chk({tag, "_we_pulses"}, wep, e_we);
        if (e_we == 1) chk({tag, "_we_addr"}, {22'h0, wea}, {22'h0, a[RAM_AW+1:2]});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] cr, a, d;
        int          first, second, k;

        vecs[0]  = '{1'b1, 32'hF000_0000, 32'h0000_A5A5, 16'h0000, 32'h0000_0000, 1, 1'b0};
        vecs[1]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h0000, 32'h0000_A5A5, 1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 16'h0000, 32'h0000_A5A5, 3, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'h1234_5678, 3, 1'b0};
        vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0,         16'hBEEF, 32'h0000_BEEF, 1, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         16'h0000, UNMAP_RD,      1, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'h0000, UNMAP_RD,      3, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0FFF, 32'h0,         16'h0000, 32'hCAFE_F00D, 3, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_1000, 32'hDEAD_0000, 16'h0000, 32'hCAFE_F00D, 1, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_1000, 32'h0,         16'h0000, UNMAP_RD,      1, 1'b1};
        vecs[10] = '{1'b0, 32'hF000_000C, 32'h0,         16'h0000, UNMAP_RD,      1, 1'b1};
        vecs[11] = '{1'b1, 32'hF123_4560, 32'h0000_3C3C, 16'h0000, UNMAP_RD,      1, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         16'h0000, 32'h0000_0000, 3, 1'b0};

        reset = 1'b0; CPU_MIO = 1'b0; mem_w = 1'b0; Addr_out = '0; Data_out = '0; sw = '0;
        mem_clr = 1'b1;
        for (int i = 0; i < (1 << RAM_AW); i++) ref_mem[i] = '0;
        ref_led = '0; last_rd = '0; cnt_base = '0; cnt_base_cyc = '0;

        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk("rst_data_in", Data_in, 32'h0);
        chk("rst_ready", {31'b0, MIO_ready}, 32'h0);
        chk("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_counter", counter_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cnt_base = '0; cnt_base_cyc = cyc;

        for (int i = 0; i < 13; i++) begin
            sw = vecs[i].sw;
            do_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, 1'b1,
                     vecs[i].rd, vecs[i].lat, vecs[i].err, cr);
        end

        // Counter load then wrap through all-ones
        do_check("cnt_load", 1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 1'b0, '0, 0, 1'b0, cr);
        chk("cnt_loaded_value", cr, 32'hFFFF_FFFE);
        chk("cnt_plus1", counter_out, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("cnt_wrap", counter_out, 32'h0000_0000);

        // Back-to-back requests with CPU_MIO held high
        @(negedge clk);
        CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h8000_0000;
        first = -1; second = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (MIO_ready === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        @(negedge clk);
        CPU_MIO = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_first_latency", first, 1);
        chk("b2b_gap", second - first, 2);
        chk("b2b_rdata", Data_in, UNMAP_RD);
        last_rd = UNMAP_RD;

        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                0, 1:    a = $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(4032, 4095);
                2:       a = {4'hF, 24'($urandom), 2'($urandom_range(0, 2)), 2'($urandom)};
                3:       a = {4'hF, 24'($urandom), 2'b11, 2'($urandom)};
                4:       a = $urandom;
                default: a = 32'h0000_1000 + $urandom_range(0, 255);
            endcase
            d  = $urandom;
            sw = 16'($urandom);
            do_check("rand", 1'($urandom), a, d, 1'b0, '0, 0, 1'b0, cr);
        end

        // Reset asserted during a RAM wait state aborts the write
        do_check("pre_rst_led", 1'b1, 32'hF000_0000, 32'h0000_1234, 1'b0, '0, 0, 1'b0, cr);
        @(negedge clk);
        CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h0000_0200; Data_out = 32'h5555_AAAA;
        @(posedge clk); #1;
        chk("midrst_we_before", {31'b0, ram_we}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_we", {31'b0, ram_we}, 32'h0);
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_counter", counter_out, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_ready", {31'b0, MIO_ready}, 32'h0);
        end
        @(negedge clk);
        CPU_MIO = 1'b0;
        reset = 1'b1;
        ref_led = '0; last_rd = '0; cnt_base = '0; cnt_base_cyc = cyc;
        do_check("post_rst_ram", 1'b0, 32'h0000_0200, 32'h0, 1'b0, '0, 0, 1'b0, cr);
        do_check("post_rst_led", 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'h0, 1, 1'b0, cr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
